// File: rtl/data_memory.sv
// rtl/data_memory.sv - Hack CPU data-memory responder: RAM, screen shadow + write FIFO, keyboard register
module data_memory #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        scr_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [15:0] ram_mem       [0:16383];
  logic [15:0] shadow_mem    [0:8191];
  logic [12:0] fifo_addr_mem [0:FIFO_DEPTH-1];
  logic [15:0] fifo_data_mem [0:FIFO_DEPTH-1];

  logic [15:0]   kbd_q, kbd_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic sel_ram, sel_scr, sel_kbd;
  logic ram_we, scr_we, push, pop;

  always_comb begin
    sel_ram = (addressM[15:14] == 2'b00);
    sel_scr = (addressM[15:13] == 3'b010);
    sel_kbd = (addressM == 16'h6000);
  end

  always_comb begin
    inM = 16'h0000;
    if (sel_ram)      inM = ram_mem[addressM[13:0]];
    else if (sel_scr) inM = shadow_mem[addressM[12:0]];
    else if (sel_kbd) inM = kbd_q;
  end

  assign kbd_ready    = !reset;
  assign scr_valid    = (count_q != '0);
  assign scr_addr     = fifo_addr_mem[rd_ptr_q];
  assign scr_data     = fifo_data_mem[rd_ptr_q];
  assign scr_overflow = ovf_q;

  // Reset gates every write and handshake, so nothing below needs its own reset check.
  always_comb begin
    ram_we   = writeM && sel_ram && !reset;
    scr_we   = writeM && sel_scr && !reset;
    pop      = scr_valid && scr_ready && !reset;
    push     = scr_we && ((count_q != FULL_CNT) || pop);
    kbd_d    = kbd_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (kbd_valid && kbd_ready) kbd_d = kbd_data;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (scr_we && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      kbd_q    <= kbd_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Array contents survive reset; only the write enables are gated by it.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[addressM[13:0]] <= outM;
    if (scr_we) shadow_mem[addressM[12:0]] <= outM;
    if (push) begin
      fifo_addr_mem[wr_ptr_q] <= addressM[12:0];
      fifo_data_mem[wr_ptr_q] <= outM;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory with a queue/array reference model
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic [15:0] addressM, outM, inM, kbd_data, scr_data;
  logic        writeM, kbd_valid, kbd_ready, scr_valid, scr_ready, scr_overflow;
  logic [12:0] scr_addr;

  data_memory #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_valid(scr_valid),
    .scr_ready(scr_ready), .scr_overflow(scr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem_m [int];
  logic [15:0] kbd_m = 16'h0;
  logic        ovf_m = 1'b0;
  logic [28:0] exp_q [$];
  int          pend_count = 0;
  int          vis_count = 0;
  bit          started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: check the combinational read, advance the model, clock the DUT.
  task automatic tick();
    int  a;
    bit  is_mem, is_scr, pop_p;
    #1;
    a      = int'(addressM);
    is_mem = (a < 32'h6000);
    is_scr = (a >= 32'h4000) && (a < 32'h6000);
    if (is_mem) begin
      if (mem_m.exists(a)) chk("inM_mem", {16'h0, inM}, {16'h0, mem_m[a]});
    end else if (a == 32'h6000) chk("inM_kbd", {16'h0, inM}, {16'h0, kbd_m});
    else chk("inM_unmapped", {16'h0, inM}, 32'h0);
    chk("kbd_ready", {31'h0, kbd_ready}, {31'h0, !reset});

    if (reset) begin
      exp_q.delete();
      pend_count = 0;
      ovf_m = 1'b0;
      kbd_m = 16'h0;
      if (writeM && is_mem) mem_m.delete(a);
    end else begin
      pop_p = (pend_count > 0) && scr_ready;
      if (writeM && is_mem) mem_m[a] = outM;
      if (writeM && is_scr) begin
        if (pend_count < 4 || pop_p) begin
          exp_q.push_back({addressM[12:0], outM});
          pend_count++;
        end else ovf_m = 1'b1;
      end
      if (pop_p) pend_count--;
      if (kbd_valid) kbd_m = kbd_data;
    end

    @(posedge clk);
    #1;
    vis_count = pend_count;
    chk("scr_overflow", {31'h0, scr_overflow}, {31'h0, ovf_m});
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      chk("scr_valid", {31'h0, scr_valid}, {31'h0, vis_count != 0});
      if (scr_valid) begin
        if (exp_q.size() == 0) chk("scr_head_unexpected", {3'h0, scr_addr, scr_data}, 32'hFFFFFFFF);
        else begin
          chk("scr_head", {3'h0, scr_addr, scr_data}, {3'h0, exp_q[0]});
          if (scr_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle();
    writeM = 0; kbd_valid = 0; reset = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    idle(); writeM = 1; addressM = a; outM = d; tick();
  endtask

  task automatic rd(input logic [15:0] a);
    idle(); addressM = a; tick();
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); tick(); reset = 0;
  endtask

  function automatic logic [15:0] pick_addr();
    int s;
    s = $urandom_range(0, 7);
    case (s)
      0:       return 16'(32'h0000 + $urandom_range(0, 31));
      1:       return 16'(32'h3FE0 + $urandom_range(0, 31));
      2:       return 16'(32'h4000 + $urandom_range(0, 31));
      3:       return 16'(32'h5FE0 + $urandom_range(0, 31));
      4:       return 16'h6000;
      5:       return 16'($urandom_range(32'h6001, 32'hFFFF));
      default: return 16'(32'h4000 + $urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    addressM = 0; outM = 0; writeM = 0; kbd_data = 0; kbd_valid = 0; scr_ready = 0;
    reset = 1;
    tick(); tick();
    chk("reset_scr_valid", {31'h0, scr_valid}, 32'h0);
    started = 1;
    idle();

    // RAM, including same-cycle read of the old value
    scr_ready = 1;
    wr(16'h0010, 16'h1111);
    wr(16'h0010, 16'h1234);
    wr(16'h3FFF, 16'hBEEF);
    rd(16'h0010);
    rd(16'h3FFF);

    // Keyboard
    do_reset();
    idle(); addressM = 16'h6000; kbd_data = 16'h0041; kbd_valid = 1; tick();
    rd(16'h6000);
    wr(16'h6000, 16'hFFFF);
    rd(16'h6000);
    chk("kbd_reg", {16'h0, inM}, 32'h0041);

    // Screen stream with display ready
    wr(16'h4005, 16'hAAAA);
    rd(16'h4005);
    chk("scr_stream_empty", exp_q.size(), 0);

    // Overflow: five writes into a stalled FIFO
    scr_ready = 0;
    for (int i = 0; i < 5; i++) wr(16'(32'h4000 + i), 16'(i + 1));
    chk("ovf_set", {31'h0, scr_overflow}, 32'h1);
    scr_ready = 1;
    for (int i = 0; i < 5; i++) rd(16'h0000);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", {31'h0, scr_valid}, 32'h0);
    rd(16'h4004);

    // Full FIFO with a simultaneous pop accepts the write
    do_reset();
    scr_ready = 0;
    for (int i = 0; i < 4; i++) wr(16'(32'h4100 + i), 16'(32'h100 + i));
    scr_ready = 1;
    wr(16'h4104, 16'h0104);
    chk("full_pop_no_ovf", {31'h0, scr_overflow}, 32'h0);
    rd(16'h0000);
    scr_ready = 0;
    rd(16'h0000);

    // Reset while holding three entries and a write in flight
    idle(); reset = 1; writeM = 1; addressM = 16'h4007; outM = 16'h7777; tick();
    chk("reset_flush", {31'h0, scr_valid}, 32'h0);
    idle();
    rd(16'h7000);
    chk("unmapped_read", {16'h0, inM}, 32'h0);
    rd(16'h0010);
    chk("ram_survives_reset", {16'h0, inM}, 32'h1234);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      idle();
      r = $urandom_range(0, 99);
      scr_ready = 1'($urandom_range(0, 1));
      addressM  = pick_addr();
      outM      = 16'($urandom);
      if (r < 45) writeM = 1;
      if (r >= 45 && r < 60) begin
        kbd_valid = 1;
        kbd_data  = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      end
      if (r == 99) reset = 1;
      tick();
    end

    idle(); scr_ready = 1;
    for (int i = 0; i < 6; i++) rd(16'h0000);
    chk("final_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Data-memory responder for the Hack-style CPU. It answers the CPU data port (`addressM`, `outM`, `writeM`, returning `inM`) through a fixed memory map:
- 16K words of general RAM.
- An 8K-word screen region, shadowed locally and forwarded to the display through a 4-entry write FIFO with a valid/ready handshake.
- A keyboard register loaded through a valid/ready handshake.

It sits between the CPU and the I/O peripherals in the top-level computer.

## Interface
Parameters:
- FIFO_DEPTH, 4, screen-write FIFO entries (power of two; 4 in this design)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- addressM  input  16  CPU data address
- outM  input  16  CPU write data
- writeM  input  1  CPU write strobe
- inM  output  16  read data to CPU (combinational from addressM)
- kbd_data  input  16  key code from keyboard interface (0 = no key)
- kbd_valid  input  1  key code valid
- kbd_ready  output  1  keyboard register accepts a code; tied 1 except during reset
- scr_addr  output  13  screen word offset at FIFO head
- scr_data  output  16  screen word data at FIFO head
- scr_valid  output  1  FIFO non-empty
- scr_ready  input  1  display accepts head entry
- scr_overflow  output  1  sticky, a screen write was dropped because the FIFO was full

## Operation
Memory map (addressM):
- 0x0000–0x3FFF: RAM.
- 0x4000–0x5FFF: screen. Offset is addressM[12:0].
- 0x6000: keyboard.
- 0x6001–0xFFFF: unmapped. Reads return 0x0000; writes are ignored.

Reads:
- inM is a pure combinational function of addressM and current state.
- RAM and screen regions return the array word.
- Keyboard returns kbd_reg.
- Reads have no side effects.

Writes (writeM=1 at a rising edge):
- RAM: array word updated.
- Screen: shadow word updated unconditionally. {addressM[12:0], outM} is pushed into the FIFO if there is space (see the FIFO rules).
- Keyboard address and unmapped addresses: no effect.

Keyboard:
- On kbd_valid & kbd_ready, kbd_reg <= kbd_data. A code of 0 means key released.
- Otherwise kbd_reg holds its value.

Screen FIFO:
- Circular buffer with read pointer, write pointer and count (0..FIFO_DEPTH).
- scr_valid = (count != 0). scr_addr and scr_data present the head entry.
- Pop when scr_valid & scr_ready.
- Push when a screen write occurs and either count < FIFO_DEPTH, or count == FIFO_DEPTH and a pop happens in the same cycle.
- Simultaneous push and pop leave count unchanged.
- A push attempted while full with no pop drops the entry and sets scr_overflow=1.
- scr_overflow is cleared only by reset.
- Pointers wrap modulo FIFO_DEPTH.
- Head outputs must stay stable while scr_valid=1 and scr_ready=0.

Reset:
- kbd_reg=0, kbd_ready=0, FIFO empty (pointers 0, count 0), scr_valid=0, scr_overflow=0.
- RAM and screen shadow contents are not cleared.
- Reset takes priority over any write or handshake in the same cycle: no push, no pop, no keyboard load.

## Timing
- Read latency 0: inM follows addressM combinationally in the same cycle.
- Write latency 1: a written word is visible on inM from the cycle after the edge.
- Same-cycle read/write to one address: inM shows the old value.
- Keyboard: a code accepted at edge N is visible on inM at address 0x6000 from cycle N+1.
- Screen: a push at edge N asserts scr_valid from cycle N+1 if the FIFO was empty. There is no combinational path from writeM to scr_valid.
- Sustained throughput: one push and one pop per cycle.
- Reset outputs: scr_valid=0, scr_overflow=0, kbd_ready=0. Other outputs:
  - inM reads the current array or register.
  - scr_addr and scr_data are don't-care while scr_valid=0.
- kbd_ready returns to 1 in the first cycle after reset deasserts.

## Test plan
- RAM: write 0x1234 to 0x0010, then write 0xBEEF to 0x3FFF → the following reads return 0x1234 and 0xBEEF. A same-cycle read during the write to 0x0010 returns the prior value.
- Keyboard: reset, then kbd_data=0x0041 with kbd_valid=1 for 1 cycle → inM at 0x6000 reads 0x0000 in that cycle and 0x0041 afterward. A write of 0xFFFF to 0x6000 leaves it at 0x0041.
- Screen stream, scr_ready=1: write 0xAAAA to 0x4005 → next cycle scr_valid=1, scr_addr=0x0005, scr_data=0xAAAA, popped that cycle. A read of 0x4005 returns 0xAAAA.
- Overflow: scr_ready=0, five writes to 0x4000–0x4004 with data 1–5 → count 4, scr_overflow=1. Then scr_ready=1 drains data 1,2,3,4 in order with addresses 0–3. The shadow at 0x4004 still reads 5.
- Full plus simultaneous pop: FIFO full with scr_ready=1 and a screen write in the same cycle → push accepted, count stays 4, scr_overflow stays 0.
- Unmapped and reset: a read of 0x7000 returns 0x0000. Assert reset while the FIFO holds 3 entries and a write is in flight → scr_valid=0 next cycle and no entry is pushed. RAM word 0x0010 still reads 0x1234.
